flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
- Consumer side of the ALU condition-flag interface. Holds the architectural C/Z/N/O flags register and a small save stack for interrupt entry and return.
- Evaluates 4-bit branch condition codes against the flags and returns a registered taken/not-taken decision to the fetch/branch logic.
- Uses a valid/ready request channel and a one-entry output stage with backpressure.

Parameters:
- STACK_DEPTH, 4: number of flag snapshots the save stack holds; power of two, at least 2.
- FORWARD, 1: when 1, a request accepted in the same cycle as a flag write evaluates against the new flags; when 0, it evaluates against the old flags.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flg_we  in  1  ALU flag write strobe.
- flg_in  in  4  new flags from the ALU, ordered {C,Z,N,O} (bit3 = C).
- irq_save  in  1  push the current flags onto the save stack.
- irq_restore  in  1  pop the top of the stack into the flags register.
- req_valid  in  1  branch request valid.
- req_ready  out  1  unit can accept a request.
- req_cond  in  4  condition code.
- req_target  in  16  branch target address.
- rsp_valid  out  1  decision valid.
- rsp_ready  in  1  consumer accepts the decision.
- rsp_taken  out  1  condition true.
- rsp_target  out  16  target passed through from the accepted request.
- flags  out  4  current architectural flags {C,Z,N,O}.
- stk_err  out  1  sticky error: stack overflow or underflow.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - flags = 0, stack pointer = 0, stk_err = 0.
  - rsp_valid = 0, rsp_taken = 0, rsp_target = 0.
  - req_ready = 1 one cycle after reset release; req_ready = 0 while rst_n = 0.
  - Reset mid-operation drops any pending response.
- Flag register update priority per cycle: irq_restore, then flg_we, then hold.
  - irq_save with flg_we in the same cycle pushes the OLD flags; the register still takes flg_in.
  - irq_save with irq_restore in the same cycle is illegal: stk_err is set and both are ignored.
- Save stack:
  - A push when already holding STACK_DEPTH entries is an overflow: stk_err = 1, stack unchanged.
  - A pop when empty is an underflow: stk_err = 1, flags unchanged (flg_we still applies).
  - stk_err clears only on reset.
- Condition codes, evaluated on {C,Z,N,O} (forwarded per FORWARD):
  - 0 EQ: Z. 1 NE: ~Z.
  - 2 CS: C. 3 CC: ~C.
  - 4 MI: N. 5 PL: ~N.
  - 6 VS: O. 7 VC: ~O.
  - 8 HI: C & ~Z. 9 LS: ~C | Z.
  - 10 GE: N == O. 11 LT: N != O.
  - 12 GT: ~Z & (N == O). 13 LE: Z | (N != O).
  - 14 AL: 1. 15 NV: 0.
- Forwarding precedence: irq_restore in the same cycle as a request forwards the popped value (when FORWARD = 1).
- Handshake:
  - req_ready = ~rsp_valid | rsp_ready.
  - A request is accepted when req_valid & req_ready.
  - Latency is 1 cycle: the decision appears on rsp_* in the cycle after acceptance.
  - rsp_* hold stable while rsp_valid & ~rsp_ready.
  - rsp_valid falls after the handshake unless a new request is accepted in the same cycle; back-to-back throughput is 1 per cycle.
- Output stage: single register, two states.
  - EMPTY → FULL on accept.
  - FULL → EMPTY on rsp_ready with no accept.
  - FULL → FULL on rsp_ready with accept, or on stall.

Test Plan:
- Reset release, then flg_we = 1 with flg_in = 4'b0100 (Z) and, next cycle, request cond 0 (EQ) with target 16'h1234 → next cycle rsp_valid = 1, rsp_taken = 1, rsp_target = 16'h1234; cond 1 → rsp_taken = 0.
- FORWARD = 1 with flags = 0: flg_we with flg_in = 4'b0010 (N) and request cond 11 (LT) in the same cycle → rsp_taken = 1. With FORWARD = 0 → rsp_taken = 0.
- Sweep all 16 condition codes × all 16 flag values → rsp_taken matches the table; cond 14 always 1, cond 15 always 0.
- Hold rsp_ready = 0 for 3 cycles with 2 requests queued → req_ready = 0, rsp_* stable. Release → both responses delivered in order on consecutive cycles.
- Push flags 4'h5, 4'h3, 4'hA; set flags = 0; pop three times → flags = A, then 3, then 5. A fourth pop → stk_err = 1, flags = 5. Then STACK_DEPTH + 1 pushes → stk_err stays 1 and depth saturates.
- Assert rst_n = 0 while rsp_valid = 1 and the stack holds 2 entries → immediately rsp_valid = 0, flags = 0, stk_err = 0; a pop after release → underflow.

Source files
------------

// File: rtl/flag_cond_unit.sv
// flag_cond_unit
//   Consumer side of the ALU condition-flag interface. Holds the architectural
//   {C,Z,N,O} flags, a small save stack for interrupt entry/return, and
//   evaluates 4-bit branch condition codes into a registered taken/not-taken
//   decision behind a one-entry valid/ready output stage.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   flg_we, flg_in[3:0]        ALU flag write, {C,Z,N,O}
//   irq_save, irq_restore      push / pop the flags save stack
//   req_valid/req_ready        branch request handshake
//   req_cond[3:0]              condition code
//   req_target[15:0]           branch target
//   rsp_valid/rsp_ready        decision handshake
//   rsp_taken, rsp_target      decision and passed-through target
//   flags[3:0]                 current architectural flags
//   stk_err                    sticky stack overflow/underflow/conflict
module flag_cond_unit #(
    parameter int STACK_DEPTH = 4,
    parameter bit FORWARD     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flg_we,
    input  logic [3:0]  flg_in,
    input  logic        irq_save,
    input  logic        irq_restore,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cond,
    input  logic [15:0] req_target,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_taken,
    output logic [15:0] rsp_target,
    output logic [3:0]  flags,
    output logic        stk_err
);
    // One extra pointer bit so "full" (sp == STACK_DEPTH) is representable.
    localparam int PW = $clog2(STACK_DEPTH) + 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;

    logic [3:0]    stk [STACK_DEPTH];
    logic [PW-1:0] sp;
    logic [PW-2:0] top_idx;
    logic          stk_full, stk_empty;
    logic          do_push, do_pop, push_ok, pop_ok, err_evt;
    logic [3:0]    flags_nxt, eval_flags;
    logic          rdy_en;
    logic          accept;
    ostate_t       st, st_nxt;

    function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
        logic c, z, n, o;
        {c, z, n, o} = f;
        case (cc)
            4'd0:    cond_true = z;
            4'd1:    cond_true = ~z;
            4'd2:    cond_true = c;
            4'd3:    cond_true = ~c;
            4'd4:    cond_true = n;
            4'd5:    cond_true = ~n;
            4'd6:    cond_true = o;
            4'd7:    cond_true = ~o;
            4'd8:    cond_true = c & ~z;
            4'd9:    cond_true = ~c | z;
            4'd10:   cond_true = (n == o);
            4'd11:   cond_true = (n != o);
            4'd12:   cond_true = ~z & (n == o);
            4'd13:   cond_true = z | (n != o);
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    // Simultaneous save and restore is a conflict: neither takes effect.
    assign do_push   = irq_save & ~irq_restore;
    assign do_pop    = irq_restore & ~irq_save;
    assign stk_full  = (sp == PW'(STACK_DEPTH));
    assign stk_empty = (sp == '0);
    assign push_ok   = do_push & ~stk_full;
    assign pop_ok    = do_pop & ~stk_empty;
    assign err_evt   = (irq_save & irq_restore) | (do_push & stk_full) | (do_pop & stk_empty);
    assign top_idx   = sp[PW-2:0] - 1'b1;

    always_comb begin
        flags_nxt = flags;
        if (pop_ok)
            flags_nxt = stk[top_idx];
        else if (flg_we)
            flags_nxt = flg_in;
    end

    assign eval_flags = FORWARD ? flags_nxt : flags;

    // rdy_en keeps req_ready low during reset and for the release cycle.
    assign rsp_valid = (st == FULL);
    assign req_ready = rdy_en & (~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;

    // Stack storage needs no reset; sp defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok)
            stk[sp[PW-2:0]] <= flags;   // old flags, even with flg_we this cycle
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags   <= '0;
            sp      <= '0;
            stk_err <= 1'b0;
            rdy_en  <= 1'b0;
        end else begin
            flags  <= flags_nxt;
            rdy_en <= 1'b1;
            if (push_ok)
                sp <= sp + 1'b1;
            else if (pop_ok)
                sp <= sp - 1'b1;
            if (err_evt)
                stk_err <= 1'b1;
        end
    end

    // Output stage: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= EMPTY;
        else
            st <= st_nxt;
    end

    // Output stage: next state
    always_comb begin
        st_nxt = st;
        case (st)
            EMPTY:   if (accept) st_nxt = FULL;
            FULL:    if (rsp_ready && !accept) st_nxt = EMPTY;
            default: st_nxt = EMPTY;
        endcase
    end

    // Payload only loads on accept, so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_taken  <= 1'b0;
            rsp_target <= '0;
        end else if (accept) begin
            rsp_taken  <= cond_true(req_cond, eval_flags);
            rsp_target <= req_target;
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flg_we = 1'b0;
    logic [3:0]  flg_in = '0;
    logic        irq_save = 1'b0, irq_restore = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_cond = '0;
    logic [15:0] req_target = '0;
    logic        rsp_ready = 1'b1;

    logic        req_ready1, rsp_valid1, rsp_taken1, stk_err1;
    logic [15:0] rsp_target1;
    logic [3:0]  flags1;
    logic        req_ready0, rsp_valid0, rsp_taken0, stk_err0;
    logic [15:0] rsp_target0;
    logic [3:0]  flags0;

    flag_cond_unit #(.STACK_DEPTH(DEPTH), .FORWARD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flg_we(flg_we), .flg_in(flg_in),
        .irq_save(irq_save), .irq_restore(irq_restore),
        .req_valid(req_valid), .req_ready(req_ready1), .req_cond(req_cond),
        .req_target(req_target), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_taken(rsp_taken1), .rsp_target(rsp_target1), .flags(flags1),
        .stk_err(stk_err1));

    flag_cond_unit #(.STACK_DEPTH(DEPTH), .FORWARD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flg_we(flg_we), .flg_in(flg_in),
        .irq_save(irq_save), .irq_restore(irq_restore),
        .req_valid(req_valid), .req_ready(req_ready0), .req_cond(req_cond),
        .req_target(req_target), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_taken(rsp_taken0), .rsp_target(rsp_target0), .flags(flags0),
        .stk_err(stk_err0));

    always #5 clk = ~clk;

    typedef struct {
        bit          t1;   // expected taken, forwarding instance
        bit          t0;   // expected taken, non-forwarding instance
        logic [15:0] tgt;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;

    // reference model state
    logic [3:0] mflags;
    logic [3:0] mstk[$];
    bit         merr;
    bit         mfull;
    bit         men;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs: odd codes invert the even one.
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit C, Z, N, O, b;
        C = f[3]; Z = f[2]; N = f[1]; O = f[0];
        case (c[3:1])
            3'd0: b = Z;
            3'd1: b = C;
            3'd2: b = N;
            3'd3: b = O;
            3'd4: b = C && !Z;
            3'd5: b = (N == O);
            3'd6: b = !Z && (N == O);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    // Called at posedge+2: drive one cycle, check state, advance the model.
    task automatic cyc(input bit we, input logic [3:0] fin, input bit sv, input bit rs,
                       input bit rv, input logic [3:0] c, input logic [15:0] t,
                       input bit rr, output bit acc);
        logic [3:0] old, nf;
        bit popped, nfull;
        exp_t e;
        flg_we = we; flg_in = fin; irq_save = sv; irq_restore = rs;
        req_valid = rv; req_cond = c; req_target = t; rsp_ready = rr;
        #1;
        chk("flags", flags1, mflags);
        chk("flags_nofwd", flags0, mflags);
        chk("stk_err", stk_err1, merr);
        chk("req_ready", req_ready1, men && (!mfull || rr));
        chk("req_ready_nofwd", req_ready0, men && (!mfull || rr));
        acc = men && (!mfull || rr) && rv;
        old = mflags; nf = mflags; popped = 1'b0;
        if (sv && rs) merr = 1'b1;
        else if (rs) begin
            if (mstk.size() == 0) merr = 1'b1;
            else begin nf = mstk.pop_back(); popped = 1'b1; end
        end else if (sv) begin
            if (mstk.size() == DEPTH) merr = 1'b1;
            else mstk.push_back(old);
        end
        if (!popped && we) nf = fin;
        mflags = nf;
        e.t1 = ref_cond(c, nf); e.t0 = ref_cond(c, old); e.tgt = t;
        nfull = acc || (mfull && !rr);
        @(posedge clk);
        if (acc) sb.push_back(e);
        mfull = nfull;
        men = 1'b1;
        #2;
    endtask

    task automatic idle(input bit rr);
        bit a;
        cyc(0, 4'h0, 0, 0, 0, 4'h0, 16'h0, rr, a);
    endtask

    task automatic send(input logic [3:0] c, input logic [15:0] t, input bit rr);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++)
            cyc(0, 4'h0, 0, 0, 1, c, t, rr, a);
        if (!a) begin
            total++; bad++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    // Asserted between edges so it also exercises the asynchronous path.
    task automatic do_reset();
        rst_n = 1'b0;
        flg_we = 0; irq_save = 0; irq_restore = 0; req_valid = 0; rsp_ready = 1;
        #1;
        chk("rst_rsp_valid", rsp_valid1, 0);
        chk("rst_rsp_taken", rsp_taken1, 0);
        chk("rst_rsp_target", rsp_target1, 0);
        chk("rst_req_ready", req_ready1, 0);
        chk("rst_flags", flags1, 0);
        chk("rst_stk_err", stk_err1, 0);
        chk("rst_rsp_valid_nofwd", rsp_valid0, 0);
        sb.delete(); mstk.delete();
        mflags = 4'h0; merr = 1'b0; mfull = 1'b0; men = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Monitor: at negedge, both handshake sides are stable for the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rsp_valid", rsp_valid1, sb.size() != 0);
            chk("rsp_valid_nofwd", rsp_valid0, sb.size() != 0);
            if (rsp_valid1 && sb.size() != 0) begin
                chk("rsp_taken", rsp_taken1, sb[0].t1);
                chk("rsp_taken_nofwd", rsp_taken0, sb[0].t0);
                chk("rsp_target", rsp_target1, sb[0].tgt);
                chk("rsp_target_nofwd", rsp_target0, sb[0].tgt);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        mflags = 0; merr = 0; mfull = 0; men = 0;
        @(posedge clk); #2;
        do_reset();

        // Z set, then EQ / NE
        cyc(1, 4'b0100, 0, 0, 0, 4'h0, 16'h0, 1, a);
        send(4'd0, 16'h1234, 1);
        send(4'd1, 16'h1235, 1);

        // forwarding: flags=0, write N and request LT in the same cycle
        cyc(1, 4'b0000, 0, 0, 0, 4'h0, 16'h0, 1, a);
        cyc(1, 4'b0010, 0, 0, 1, 4'd11, 16'hBEEF, 1, a);
        idle(1);

        // full condition x flags sweep
        for (int f = 0; f < 16; f++) begin
            cyc(1, 4'(f), 0, 0, 0, 4'h0, 16'h0, 1, a);
            for (int c = 0; c < 16; c++)
                send(4'(c), 16'(f * 16 + c), 1);
        end
        idle(1);

        // backpressure: two requests queued behind a 3-cycle stall
        send(4'd14, 16'hAAAA, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 4'h0, 0, 0, 1, 4'd15, 16'h5555, 0, a);
        cyc(0, 4'h0, 0, 0, 1, 4'd15, 16'h5555, 1, a);
        idle(1);
        idle(1);

        // save stack: push 5,3,A; flags -> 0; pop x3; underflow; overflow
        cyc(1, 4'h5, 0, 0, 0, 4'h0, 16'h0, 1, a);
        cyc(1, 4'h3, 1, 0, 0, 4'h0, 16'h0, 1, a);
        cyc(1, 4'hA, 1, 0, 0, 4'h0, 16'h0, 1, a);
        cyc(1, 4'h0, 1, 0, 0, 4'h0, 16'h0, 1, a);
        for (int i = 0; i < 4; i++)
            cyc(0, 4'h0, 0, 1, 0, 4'h0, 16'h0, 1, a);
        idle(1);
        for (int i = 0; i < DEPTH + 1; i++)
            cyc(1, 4'(i + 6), 1, 0, 0, 4'h0, 16'h0, 1, a);
        // restore with a request in the same cycle forwards the popped value
        cyc(0, 4'h0, 0, 1, 1, 4'd4, 16'h0C0C, 1, a);
        cyc(0, 4'h0, 0, 1, 0, 4'h0, 16'h0, 1, a);
        // stack holds 2, response pending and stalled, then reset mid-flight
        send(4'd14, 16'h7777, 0);
        idle(0);
        do_reset();
        idle(1);
        cyc(0, 4'h0, 0, 1, 0, 4'h0, 16'h0, 1, a);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) == 0, 4'($urandom),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) != 0, 4'($urandom), 16'($urandom),
                $urandom_range(0, 3) != 0, a);
        end

        for (int i = 0; i < 3; i++) idle(1);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
